// File: rtl/alu_seq_unit.sv
// alu_seq_unit: ALU decode plus execute stage with single-cycle ops and an iterative shift-add multiply.
module alu_seq_unit #(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             illegal
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_e;
  typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOR, OP_SLT, OP_MUL, OP_ILL} op_e;
  state_e           state_q, state_d;
  op_e              op;
  logic [WIDTH-1:0] result_q, result_d, mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
  logic [WIDTH-1:0] sum, diff, res_sc;
  logic [CW-1:0]    count_q, count_d;
  logic             zero_q, zero_d, ovf_q, ovf_d, ill_q, ill_d, done_q, done_d, ovf_sc;
  always_comb begin
    op = OP_ILL;
    if (alu_op != 2'b10) op = alu_op == 2'b00 ? OP_ADD : OP_SUB;
    else
      case (funct)
        6'b100000: op = OP_ADD;
        6'b100010: op = OP_SUB;
        6'b100100: op = OP_AND;
        6'b100101: op = OP_OR;
        6'b100111: op = OP_NOR;
        6'b101010: op = OP_SLT;
        6'b011000: op = MUL_EN ? OP_MUL : OP_ILL;
        default:   op = OP_ILL;
      endcase
  end
  assign sum  = a + b;
  assign diff = a - b;
  always_comb begin
    res_sc = '0;
    ovf_sc = 1'b0;
    case (op)
      OP_ADD: begin
        res_sc = sum;
        ovf_sc = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        res_sc = diff;
        ovf_sc = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  res_sc = a & b;
      OP_OR:   res_sc = a | b;
      OP_NOR:  res_sc = ~(a | b);
      OP_SLT:  res_sc = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      default: res_sc = '0;
    endcase
  end
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    ill_d    = ill_q;
    done_d   = 1'b0;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    count_d  = count_q;
    if (state_q == S_MUL) begin
      acc_d    = mplier_q[0] ? acc_q + mcand_q : acc_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      count_d  = count_q - 1'b1;
      if (count_q == CW'(1)) begin
        state_d  = S_DONE;
        result_d = acc_d;
        zero_d   = acc_d == '0;
        ovf_d    = 1'b0;
        ill_d    = 1'b0;
        done_d   = 1'b1;
      end
    end else if (start && op == OP_MUL) begin
      state_d  = S_MUL;
      mcand_d  = a;
      mplier_d = b;
      acc_d    = '0;
      count_d  = CW'(WIDTH);
    end else if (start) begin
      state_d  = S_DONE;
      result_d = res_sc;
      zero_d   = res_sc == '0;
      ovf_d    = ovf_sc;
      ill_d    = op == OP_ILL;
      done_d   = 1'b1;
    end else begin
      state_d = S_IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      ill_q    <= 1'b0;
      done_q   <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      ill_q    <= ill_d;
      done_q   <= done_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
    end
  end
  assign ready    = state_q != S_MUL;
  assign done     = done_q;
  assign result   = result_q;
  assign zero     = zero_q;
  assign overflow = ovf_q;
  assign illegal  = ill_q;
endmodule

// File: tb/tb_alu_seq_unit.sv
// tb_alu_seq_unit: directed checks of alu_seq_unit with MUL_EN=1 and MUL_EN=0 instances.
module tb_alu_seq_unit;
  logic        clk = 1'b0, reset = 1'b1, start = 1'b0, start1 = 1'b0;
  logic [1:0]  alu_op = 2'b00;
  logic [5:0]  funct = 6'b0;
  logic [31:0] a = '0, b = '0;
  logic        ready, done, zero, overflow, illegal;
  logic [31:0] result;
  logic        ready1, done1, zero1, overflow1, illegal1;
  logic [31:0] result1;
  int          total = 0, passed = 0;
  logic        seen;
  alu_seq_unit #(.WIDTH(32), .MUL_EN(1'b1)) u0 (
    .clk(clk), .reset(reset), .start(start), .alu_op(alu_op), .funct(funct), .a(a), .b(b),
    .ready(ready), .done(done), .result(result), .zero(zero), .overflow(overflow), .illegal(illegal)
  );
  alu_seq_unit #(.WIDTH(32), .MUL_EN(1'b0)) u1 (
    .clk(clk), .reset(reset), .start(start1), .alu_op(alu_op), .funct(funct), .a(a), .b(b),
    .ready(ready1), .done(done1), .result(result1), .zero(zero1), .overflow(overflow1), .illegal(illegal1)
  );
  always #5 clk = ~clk;
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask
  task automatic issue(input logic [1:0] op, input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; alu_op = op; funct = f; a = x; b = y;
  endtask
  initial begin
    step; step;
    reset = 1'b0;
    step;
    chk("rst_result", result, 0);
    chk("rst_zero", zero, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_ill", illegal, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", ready, 1);
    issue(2'b00, 6'b0, 32'd5, 32'd7);
    step;
    start = 1'b0;
    chk("add_done", done, 1);
    chk("add_result", result, 12);
    chk("add_zero", zero, 0);
    chk("add_ovf", overflow, 0);
    chk("add_ready", ready, 1);
    step;
    chk("add_done_drop", done, 0);
    chk("add_result_hold", result, 12);
    issue(2'b10, 6'b100010, 32'h8000_0000, 32'd1);
    step;
    chk("sub_done", done, 1);
    chk("sub_result", result, 32'h7FFF_FFFF);
    chk("sub_ovf", overflow, 1);
    issue(2'b10, 6'b101010, 32'h8000_0000, 32'd1);
    step;
    start = 1'b0;
    chk("slt_done", done, 1);
    chk("slt_result", result, 1);
    chk("slt_ovf", overflow, 0);
    issue(2'b10, 6'b100100, 32'hF0F0_F0F0, 32'hFF00_FF00);
    step;
    chk("and_done", done, 1);
    chk("and_result", result, 32'hF000_F000);
    issue(2'b10, 6'b100111, 32'd0, 32'd0);
    step;
    start = 1'b0;
    chk("nor_done", done, 1);
    chk("nor_result", result, 32'hFFFF_FFFF);
    step;
    chk("nor_done_drop", done, 0);
    issue(2'b10, 6'b011000, 32'h0001_2345, 32'h0000_0100);
    step;
    for (int i = 1; i <= 32; i++) begin
      chk($sformatf("mul_busy_%0d", i), {ready, done}, 2'b00);
      if (i == 5) issue(2'b00, 6'b0, 32'd1, 32'd1);
      else start = 1'b0;
      step;
    end
    start = 1'b0;
    chk("mul_done", done, 1);
    chk("mul_result", result, 32'h0123_4500);
    chk("mul_ovf", overflow, 0);
    chk("mul_ready", ready, 1);
    step;
    chk("mul_done_drop", done, 0);
    chk("mul_result_hold", result, 32'h0123_4500);
    issue(2'b10, 6'b111111, 32'd9, 32'd9);
    step;
    start = 1'b0;
    chk("ill_done", done, 1);
    chk("ill_flag", illegal, 1);
    chk("ill_result", result, 0);
    chk("ill_zero", zero, 1);
    chk("ill_ovf", overflow, 0);
    issue(2'b00, 6'b0, 32'd2, 32'd3);
    step;
    start = 1'b0;
    chk("ill_clear", illegal, 0);
    chk("ill_clear_result", result, 5);
    chk("ill_clear_zero", zero, 0);
    start1 = 1'b1; alu_op = 2'b10; funct = 6'b011000; a = 32'd3; b = 32'd4;
    step;
    start1 = 1'b0;
    chk("nomul_done", done1, 1);
    chk("nomul_ill", illegal1, 1);
    chk("nomul_result", result1, 0);
    chk("nomul_zero", zero1, 1);
    chk("nomul_ready", ready1, 1);
    chk("nomul_u0_idle", done, 0);
    issue(2'b10, 6'b011000, 32'd3, 32'd4);
    step;
    start = 1'b0;
    for (int i = 1; i < 10; i++) step;
    chk("abort_busy", ready, 0);
    reset = 1'b1;
    step;
    reset = 1'b0;
    chk("abort_ready", ready, 1);
    chk("abort_done", done, 0);
    chk("abort_result", result, 0);
    chk("abort_zero", zero, 0);
    chk("abort_ill", illegal, 0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      seen = seen | done;
      step;
    end
    chk("abort_no_done", seen, 0);
    issue(2'b00, 6'b0, 32'd1, 32'd1);
    step;
    start = 1'b0;
    chk("post_abort_done", done, 1);
    chk("post_abort_result", result, 2);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
